// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired sequencer: opcode constants, state and
// instruction-class encodings. CTRL_MULDIV_EN enables the mul/div execute states.
package cpu_ctrl_pkg;

   localparam int unsigned CPU_OPW = 5;
   typedef logic [CPU_OPW-1:0] opcode_t;

   localparam opcode_t OP_LD   = 5'b00000;
   localparam opcode_t OP_LDI  = 5'b00001;
   localparam opcode_t OP_ST   = 5'b00010;
   localparam opcode_t OP_ADD  = 5'b00011;
   localparam opcode_t OP_SUB  = 5'b00100;
   localparam opcode_t OP_AND  = 5'b00101;
   localparam opcode_t OP_OR   = 5'b00110;
   localparam opcode_t OP_ROR  = 5'b00111;
   localparam opcode_t OP_ROL  = 5'b01000;
   localparam opcode_t OP_SHR  = 5'b01001;
   localparam opcode_t OP_SHRA = 5'b01010;
   localparam opcode_t OP_SHL  = 5'b01011;
   localparam opcode_t OP_ADDI = 5'b01100;
   localparam opcode_t OP_ANDI = 5'b01101;
   localparam opcode_t OP_ORI  = 5'b01110;
   localparam opcode_t OP_DIV  = 5'b01111;
   localparam opcode_t OP_MUL  = 5'b10000;
   localparam opcode_t OP_NEG  = 5'b10001;
   localparam opcode_t OP_NOT  = 5'b10010;
   localparam opcode_t OP_BR   = 5'b10011;
   localparam opcode_t OP_JR   = 5'b10100;
   localparam opcode_t OP_JAL  = 5'b10101;
   localparam opcode_t OP_IN   = 5'b10110;
   localparam opcode_t OP_OUT  = 5'b10111;
   localparam opcode_t OP_MFHI = 5'b11000;
   localparam opcode_t OP_MFLO = 5'b11001;
   localparam opcode_t OP_NOP  = 5'b11010;
   localparam opcode_t OP_HALT = 5'b11011;

   typedef enum logic [3:0] {
      ST_RESET = 4'd0,
      ST_T0    = 4'd1,
      ST_T1    = 4'd2,
      ST_T2    = 4'd3,
      ST_T3    = 4'd4,
      ST_T4    = 4'd5,
      ST_T5    = 4'd6,
      ST_T6    = 4'd7,
      ST_T7    = 4'd8,
      ST_HALT  = 4'd9
   } state_t;

   typedef enum logic [3:0] {
      IC_ALU, IC_IMM, IC_UNARY, IC_LD, IC_LDI, IC_ST, IC_BR, IC_JR,
      IC_JAL, IC_IN, IC_OUT, IC_MFHI, IC_MFLO, IC_MULDIV, IC_NOP, IC_HALT
   } iclass_t;

   // Final execute state of each class; the edge leaving it returns to T0 or HALT.
   function automatic state_t last_state(input iclass_t c);
      case (c)
         IC_ALU, IC_IMM, IC_LDI: return ST_T5;
         IC_LD, IC_ST:           return ST_T7;
         IC_BR:                  return ST_T6;
         IC_UNARY, IC_JAL:       return ST_T4;
`ifdef CTRL_MULDIV_EN
         IC_MULDIV:              return ST_T6;
`endif
         default:                return ST_T3;
      endcase
   endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode-to-class decode. With CTRL_MULDIV_EN undefined,
// mul and div fall into the nop class.
module ctrl_decode
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned OPW = CPU_OPW
) (
   input  logic [OPW-1:0] opcode_i,
   output iclass_t        iclass_o
);

   always_comb begin
      iclass_o = IC_NOP;
      case (opcode_i)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
         OP_ROL, OP_SHR, OP_SHRA, OP_SHL:  iclass_o = IC_ALU;
         OP_ADDI, OP_ANDI, OP_ORI:         iclass_o = IC_IMM;
         OP_NEG, OP_NOT:                   iclass_o = IC_UNARY;
         OP_LD:                            iclass_o = IC_LD;
         OP_LDI:                           iclass_o = IC_LDI;
         OP_ST:                            iclass_o = IC_ST;
         OP_BR:                            iclass_o = IC_BR;
         OP_JR:                            iclass_o = IC_JR;
         OP_JAL:                           iclass_o = IC_JAL;
         OP_IN:                            iclass_o = IC_IN;
         OP_OUT:                           iclass_o = IC_OUT;
         OP_MFHI:                          iclass_o = IC_MFHI;
         OP_MFLO:                          iclass_o = IC_MFLO;
         OP_HALT:                          iclass_o = IC_HALT;
`ifdef CTRL_MULDIV_EN
         OP_MUL, OP_DIV:                   iclass_o = IC_MULDIV;
`endif
         default:                          iclass_o = IC_NOP;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// Hardwired fetch/execute sequencer driving every datapath strobe.
// CTRL_MULDIV_EN adds the mul/div execute states (T3-T6).
module control_unit
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned OPW = CPU_OPW
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic [31:0] IRregister,
   input  logic        CON,
   input  logic        Stop,
   output logic        Run,
   output logic        HIin,
   output logic        LOin,
   output logic        PCin,
   output logic        MDRin,
   output logic        Zin,
   output logic        Yin,
   output logic        MARin,
   output logic        IRin,
   output logic        CONin,
   output logic        OUTPORTin,
   output logic        HIout,
   output logic        LOout,
   output logic        ZHIout,
   output logic        ZLOout,
   output logic        PCout,
   output logic        MDRout,
   output logic        INPORTout,
   output logic        Yout,
   output logic        Cout,
   output logic        BAout,
   output logic        Rout,
   output logic        Gra,
   output logic        Grb,
   output logic        Grc,
   output logic        Rin,
   output logic        Read,
   output logic        IncPC,
   output logic        write
);

   state_t  state_q, state_d;
   iclass_t iclass;
   logic    unused_ir;

   assign unused_ir = ^IRregister[31-OPW:0];

   ctrl_decode #(.OPW(OPW)) u_decode (
      .opcode_i (IRregister[31 -: OPW]),
      .iclass_o (iclass)
   );

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) state_q <= ST_RESET;
      else       state_q <= state_d;
   end

   // Stop is only consulted on the edge leaving an instruction's final state.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RESET:            state_d = ST_T0;
         ST_HALT:             state_d = ST_HALT;
         ST_T0, ST_T1, ST_T2: state_d = state_t'(state_q + 4'd1);
         default: begin
            if (iclass == IC_HALT)                 state_d = ST_HALT;
            else if (state_q == last_state(iclass)) state_d = Stop ? ST_HALT : ST_T0;
            else                                   state_d = state_t'(state_q + 4'd1);
         end
      endcase
   end

   always_comb begin
      {HIin, LOin, PCin, MDRin, Zin, Yin, MARin, IRin, CONin, OUTPORTin} = '0;
      {HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, Yout, Cout, BAout, Rout} = '0;
      {Gra, Grb, Grc, Rin, Read, IncPC, write} = '0;
      Run = (state_q != ST_RESET) && (state_q != ST_HALT);
      case (state_q)
         ST_T0: begin PCout = 1'b1; MARin = 1'b1; end
         ST_T1: begin Read = 1'b1; MDRin = 1'b1; PCin = 1'b1; IncPC = 1'b1; end
         ST_T2: begin MDRout = 1'b1; IRin = 1'b1; end
         ST_T3: begin
            case (iclass)
               IC_ALU, IC_IMM:         begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
               IC_LD, IC_LDI, IC_ST:   begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
               IC_UNARY:               begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; end
               IC_BR:                  begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
               IC_JR:                  begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
               IC_JAL:                 begin PCout = 1'b1; Grb = 1'b1; Rin = 1'b1; end
               IC_IN:                  begin INPORTout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
               IC_OUT:                 begin Gra = 1'b1; Rout = 1'b1; OUTPORTin = 1'b1; end
               IC_MFHI:                begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
               IC_MFLO:                begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
`ifdef CTRL_MULDIV_EN
               IC_MULDIV:              begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
`endif
               default: ;
            endcase
         end
         ST_T4: begin
            case (iclass)
               IC_ALU:                       begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; end
               IC_IMM, IC_LD, IC_LDI, IC_ST: begin Cout = 1'b1; Zin = 1'b1; end
               IC_UNARY:                     begin ZLOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
               IC_BR:                        begin PCout = 1'b1; Yin = 1'b1; end
               IC_JAL:                       begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
`ifdef CTRL_MULDIV_EN
               IC_MULDIV:                    begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; end
`endif
               default: ;
            endcase
         end
         ST_T5: begin
            case (iclass)
               IC_ALU, IC_IMM, IC_LDI: begin ZLOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
               IC_LD, IC_ST:           begin ZLOout = 1'b1; MARin = 1'b1; end
               IC_BR:                  begin Cout = 1'b1; Zin = 1'b1; end
`ifdef CTRL_MULDIV_EN
               IC_MULDIV:              begin ZLOout = 1'b1; LOin = 1'b1; end
`endif
               default: ;
            endcase
         end
         ST_T6: begin
            case (iclass)
               IC_LD:     begin Read = 1'b1; MDRin = 1'b1; end
               IC_ST:     begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
               // Branch not taken leaves T6 as a bubble.
               IC_BR:     begin ZLOout = CON; PCin = CON; end
`ifdef CTRL_MULDIV_EN
               IC_MULDIV: begin ZHIout = 1'b1; HIin = 1'b1; end
`endif
               default: ;
            endcase
         end
         ST_T7: begin
            case (iclass)
               IC_LD:   begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
               IC_ST:   write = 1'b1;
               default: ;
            endcase
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_control_unit.sv
// Randomized bench: per-opcode strobe sequences from a table model, compared
// every cycle; includes reset abort, Stop and halt scenarios.
module tb_control_unit;

   localparam int W = 29;

   localparam logic [W-1:0] M_PCOUT = 29'd1 << 0;
   localparam logic [W-1:0] M_MARIN = 29'd1 << 1;
   localparam logic [W-1:0] M_READ  = 29'd1 << 2;
   localparam logic [W-1:0] M_MDRIN = 29'd1 << 3;
   localparam logic [W-1:0] M_PCIN  = 29'd1 << 4;
   localparam logic [W-1:0] M_INCPC = 29'd1 << 5;
   localparam logic [W-1:0] M_MDROUT= 29'd1 << 6;
   localparam logic [W-1:0] M_IRIN  = 29'd1 << 7;
   localparam logic [W-1:0] M_GRB   = 29'd1 << 8;
   localparam logic [W-1:0] M_ROUT  = 29'd1 << 9;
   localparam logic [W-1:0] M_YIN   = 29'd1 << 10;
   localparam logic [W-1:0] M_GRC   = 29'd1 << 11;
   localparam logic [W-1:0] M_ZIN   = 29'd1 << 12;
   localparam logic [W-1:0] M_ZLO   = 29'd1 << 13;
   localparam logic [W-1:0] M_GRA   = 29'd1 << 14;
   localparam logic [W-1:0] M_RIN   = 29'd1 << 15;
   localparam logic [W-1:0] M_COUT  = 29'd1 << 16;
   localparam logic [W-1:0] M_BAOUT = 29'd1 << 17;
   localparam logic [W-1:0] M_CONIN = 29'd1 << 18;
   localparam logic [W-1:0] M_INPORT= 29'd1 << 19;
   localparam logic [W-1:0] M_OUTPRT= 29'd1 << 20;
   localparam logic [W-1:0] M_HIOUT = 29'd1 << 21;
   localparam logic [W-1:0] M_LOOUT = 29'd1 << 22;
   localparam logic [W-1:0] M_ZHI   = 29'd1 << 23;
   localparam logic [W-1:0] M_LOIN  = 29'd1 << 24;
   localparam logic [W-1:0] M_HIIN  = 29'd1 << 25;
   localparam logic [W-1:0] M_WRITE = 29'd1 << 26;
   localparam logic [W-1:0] M_RUN   = 29'd1 << 27;

   logic        Clock, Reset, CON, Stop;
   logic [31:0] IRregister;
   logic Run, HIin, LOin, PCin, MDRin, Zin, Yin, MARin, IRin, CONin, OUTPORTin;
   logic HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, Yout, Cout, BAout, Rout;
   logic Gra, Grb, Grc, Rin, Read, IncPC, write;
   logic [W-1:0] dut_vec;

   assign dut_vec = {Yout, Run, write, HIin, LOin, ZHIout, LOout, HIout, OUTPORTin,
                     INPORTout, CONin, BAout, Cout, Rin, Gra, ZLOout, Zin, Grc, Yin,
                     Rout, Grb, IRin, MDRout, IncPC, PCin, MDRin, Read, MARin, PCout};

   control_unit dut (
      .Clock(Clock), .Reset(Reset), .IRregister(IRregister), .CON(CON), .Stop(Stop),
      .Run(Run), .HIin(HIin), .LOin(LOin), .PCin(PCin), .MDRin(MDRin), .Zin(Zin),
      .Yin(Yin), .MARin(MARin), .IRin(IRin), .CONin(CONin), .OUTPORTin(OUTPORTin),
      .HIout(HIout), .LOout(LOout), .ZHIout(ZHIout), .ZLOout(ZLOout), .PCout(PCout),
      .MDRout(MDRout), .INPORTout(INPORTout), .Yout(Yout), .Cout(Cout), .BAout(BAout),
      .Rout(Rout), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Read(Read),
      .IncPC(IncPC), .write(write)
   );

   // clock / reset
   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   int           n_vec  = 0;
   int           n_miss = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] exp_cur   = '0;
   bit           exp_valid = 1'b0;
   bit           ends_halt;
   string        cur_name  = "idle";

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_miss++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // compare process: outputs are settled mid-cycle
   always @(negedge Clock) begin
      if (exp_valid) check(cur_name, dut_vec, exp_cur);
   end

   // reference model: full per-cycle strobe list of one instruction
   task automatic push(input logic [W-1:0] m);
      exp_q.push_back(m | M_RUN);
   endtask

   task automatic build_seq(input logic [4:0] op, input bit con);
      exp_q.delete();
      ends_halt = 1'b0;
      push(M_PCOUT | M_MARIN);
      push(M_READ | M_MDRIN | M_PCIN | M_INCPC);
      push(M_MDROUT | M_IRIN);
      case (op)
         5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11: begin
            push(M_GRB | M_ROUT | M_YIN); push(M_GRC | M_ROUT | M_ZIN); push(M_ZLO | M_GRA | M_RIN);
         end
         5'd12, 5'd13, 5'd14: begin
            push(M_GRB | M_ROUT | M_YIN); push(M_COUT | M_ZIN); push(M_ZLO | M_GRA | M_RIN);
         end
         5'd17, 5'd18: begin push(M_GRB | M_ROUT | M_ZIN); push(M_ZLO | M_GRA | M_RIN); end
         5'd1: begin
            push(M_GRB | M_BAOUT | M_YIN); push(M_COUT | M_ZIN); push(M_ZLO | M_GRA | M_RIN);
         end
         5'd0: begin
            push(M_GRB | M_BAOUT | M_YIN); push(M_COUT | M_ZIN); push(M_ZLO | M_MARIN);
            push(M_READ | M_MDRIN); push(M_MDROUT | M_GRA | M_RIN);
         end
         5'd2: begin
            push(M_GRB | M_BAOUT | M_YIN); push(M_COUT | M_ZIN); push(M_ZLO | M_MARIN);
            push(M_GRA | M_ROUT | M_MDRIN); push(M_WRITE);
         end
         5'd19: begin
            push(M_GRA | M_ROUT | M_CONIN); push(M_PCOUT | M_YIN); push(M_COUT | M_ZIN);
            push(con ? (M_ZLO | M_PCIN) : '0);
         end
         5'd20: push(M_GRA | M_ROUT | M_PCIN);
         5'd21: begin push(M_PCOUT | M_GRB | M_RIN); push(M_GRA | M_ROUT | M_PCIN); end
         5'd22: push(M_INPORT | M_GRA | M_RIN);
         5'd23: push(M_GRA | M_ROUT | M_OUTPRT);
         5'd24: push(M_HIOUT | M_GRA | M_RIN);
         5'd25: push(M_LOOUT | M_GRA | M_RIN);
         5'd27: begin push('0); ends_halt = 1'b1; end
`ifdef CTRL_MULDIV_EN
         5'd15, 5'd16: begin
            push(M_GRA | M_ROUT | M_YIN); push(M_GRB | M_ROUT | M_ZIN);
            push(M_ZLO | M_LOIN); push(M_ZHI | M_HIIN);
         end
`endif
         default: push('0);
      endcase
   endtask

   // driver: stop_mode 0 = never, 1 = random each cycle, 2 = only in final state
   task automatic run_instr(input logic [31:0] ir, input bit con, input int stop_mode,
                            input int abort_at, output bit halted);
      int n;
      bit s;
      build_seq(ir[31:27], con);
      n = exp_q.size();
      halted = 1'b0;
      cur_name = $sformatf("op%0d", ir[31:27]);
      for (int i = 0; i < n; i++) begin
         @(posedge Clock); #2;
         if (i == 0) begin IRregister = ir; CON = con; end
         s = (stop_mode == 1) ? ($urandom_range(0, 7) == 0) : (stop_mode == 2 && i == n - 1);
         Stop = s;
         exp_cur = exp_q[i];
         exp_valid = 1'b1;
         if (i == n - 1 && (s || ends_halt)) halted = 1'b1;
         if (i == abort_at) begin
            @(negedge Clock); #1;
            Reset = 1'b1;
            #1;
            check("abort_drop", dut_vec, '0);
            exp_valid = 1'b0;
            @(posedge Clock); #2;
            Reset = 1'b0;
            Stop = 1'b0;
            cur_name = "post_abort_reset";
            exp_cur = '0;
            exp_valid = 1'b1;
            halted = 1'b0;
            return;
         end
      end
   endtask

   task automatic halt_then_reset();
      cur_name = "halt";
      for (int i = 0; i < 20; i++) begin
         @(posedge Clock); #2;
         Stop = 1'($urandom_range(0, 1));
         exp_cur = '0;
         exp_valid = 1'b1;
      end
      @(posedge Clock); #2;
      exp_valid = 1'b0;
      Reset = 1'b1;
      #1;
      check("halt_reset", dut_vec, '0);
      @(posedge Clock); #2;
      Reset = 1'b0;
      Stop = 1'b0;
      cur_name = "reset_state";
      exp_cur = '0;
      exp_valid = 1'b1;
   endtask

   initial begin
      bit h;
      logic [4:0] op;
      Reset = 1'b1; Stop = 1'b0; CON = 1'b0; IRregister = '0;
      repeat (2) @(posedge Clock);
      #2;
      check("reset_outputs", dut_vec, '0);
      Reset = 1'b0;
      cur_name = "reset_state";
      exp_cur = '0;
      exp_valid = 1'b1;

      // model pins
      build_seq(5'b01100, 1'b0); check_int("addi_len", exp_q.size(), 6);
      check("addi_t4", exp_q[4], M_COUT | M_ZIN | M_RUN);
      build_seq(5'b00000, 1'b0); check_int("ld_len", exp_q.size(), 8);
      check("ld_t7", exp_q[7], M_MDROUT | M_GRA | M_RIN | M_RUN);
      build_seq(5'b10011, 1'b0); check_int("br_len", exp_q.size(), 7);
      build_seq(5'b10101, 1'b0); check_int("jal_len", exp_q.size(), 5);
      build_seq(5'b10100, 1'b0); check_int("jr_len", exp_q.size(), 4);
`ifdef CTRL_MULDIV_EN
      build_seq(5'b10000, 1'b0); check_int("mul_len", exp_q.size(), 7);
`else
      build_seq(5'b10000, 1'b0); check_int("mul_len", exp_q.size(), 4);
`endif

      // directed instructions
      run_instr(32'h6118_0000, 1'b0, 0, -1, h);  // addi
      run_instr(32'h0088_0000, 1'b0, 0, -1, h);  // ld
      run_instr(32'h1000_0000, 1'b0, 0, -1, h);  // st
      run_instr(32'h9800_0000, 1'b1, 0, -1, h);  // br taken
      run_instr(32'h9800_0000, 1'b0, 0, -1, h);  // br not taken
      run_instr(32'h8000_0000, 1'b0, 0, -1, h);  // mul
      run_instr(32'h7800_0000, 1'b1, 0, -1, h);  // div
      run_instr(32'hA800_0000, 1'b0, 0, -1, h);  // jal
      run_instr(32'hD000_0000, 1'b0, 0, -1, h);  // nop

      // reset in T4 of add, then a fresh fetch
      run_instr(32'h1800_0000, 1'b0, 0, 4, h);
      run_instr(32'h6000_0000, 1'b0, 0, -1, h);

      // Stop in the final state of add
      run_instr(32'h1800_0000, 1'b0, 2, -1, h);
      check_int("stop_halted", int'(h), 1);
      halt_then_reset();

      // halt opcode
      run_instr(32'hD800_0000, 1'b0, 0, -1, h);
      check_int("halt_op", int'(h), 1);
      halt_then_reset();

      // random instruction stream
      for (int k = 0; k < 300; k++) begin
         op = 5'($urandom_range(0, 31));
         if (op == 5'd27 && $urandom_range(0, 3) != 0) op = 5'd3;
         run_instr({op, 27'($urandom)}, 1'($urandom_range(0, 1)), 1, -1, h);
         if (h) halt_then_reset();
      end

      @(posedge Clock); #2;
      exp_valid = 1'b0;
      @(negedge Clock);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
